// File: rtl/rr_mux_pkg.sv
// Shared definitions for the round-robin arbitrated multiplexer and its arbiter.
// Holds the arbitration-mode encodings and the channel-index width helper.
package rr_mux_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // A single channel index still needs one bit, so clog2 is clamped at 1.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational winner selection: the first requester at or after ptr wins,
// searching upward with wrap-around. A ptr of zero gives fixed lowest-index priority.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = sel_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  winner,
    output logic              any_req
);

    localparam logic [SEL_W:0] NUM_CH_W = (SEL_W+1)'(NUM_CH);

    logic [SEL_W:0]   sum;
    logic [SEL_W-1:0] pos;

    // Offsets are walked from farthest to nearest so the requester closest to
    // ptr is the last one assigned and therefore the one that sticks.
    always_comb begin
        grant   = '0;
        winner  = '0;
        sum     = '0;
        pos     = '0;
        any_req = |req;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (SEL_W+1)'(k);
            if (sum >= NUM_CH_W) begin
                sum = sum - NUM_CH_W;
            end
            pos = sum[SEL_W-1:0];
            if (req[pos]) begin
                grant      = '0;
                grant[pos] = 1'b1;
                winner     = pos;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N-channel arbitrated multiplexer feeding one registered valid/ready output stage.
// Supports round-robin or fixed lowest-index priority between the producers.
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int WIDTH   = 5,
    parameter int NUM_CH  = 4,
    parameter int RR_MODE = ARB_RR,
    parameter int SEL_W   = sel_width(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    logic [WIDTH-1:0]  ch_data [NUM_CH];
    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  winner;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  next_ptr;
    logic              any_req;
    logic              load;
    logic              xfer;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arbiter (
        .req     (in_valid),
        .ptr     (ptr),
        .grant   (grant),
        .winner  (winner),
        .any_req (any_req)
    );

    // The output slot can take a beat when empty or when its beat leaves this cycle.
    assign load     = !out_valid || out_ready;
    assign in_ready = (rst_n && load && any_req) ? grant : '0;
    assign xfer     = |in_ready;
    assign next_ptr = (winner == LAST_CH) ? '0 : winner + SEL_W'(1);

    // Output register and rotation pointer; the pointer stays at zero in fixed mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                out_data  <= ch_data[winner];
                out_sel   <= winner;
                out_valid <= 1'b1;
                if (RR_MODE == ARB_RR) begin
                    ptr <= next_ptr;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: a 4-channel round-robin unit, a 4-channel
// fixed-priority unit and a 3-channel round-robin unit, each with its own reset.
module tb_rr_mux_arbiter;
    import rr_mux_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        rst_a, rst_b, rst_c;
    logic [19:0] data_a, data_b;
    logic [14:0] data_c;
    logic [3:0]  valid_a, valid_b, ready_a, ready_b;
    logic [2:0]  valid_c, ready_c;
    logic [4:0]  odata_a, odata_b, odata_c;
    logic [1:0]  sel_a, sel_b, sel_c;
    logic        ovalid_a, ovalid_b, ovalid_c;
    logic        oready_a, oready_b, oready_c;

    rr_mux_arbiter #(.WIDTH(5), .NUM_CH(4), .RR_MODE(ARB_RR)) dut_a (
        .clk(clk), .rst_n(rst_a), .in_data(data_a), .in_valid(valid_a), .in_ready(ready_a),
        .out_data(odata_a), .out_sel(sel_a), .out_valid(ovalid_a), .out_ready(oready_a)
    );

    rr_mux_arbiter #(.WIDTH(5), .NUM_CH(4), .RR_MODE(ARB_FIXED)) dut_b (
        .clk(clk), .rst_n(rst_b), .in_data(data_b), .in_valid(valid_b), .in_ready(ready_b),
        .out_data(odata_b), .out_sel(sel_b), .out_valid(ovalid_b), .out_ready(oready_b)
    );

    rr_mux_arbiter #(.WIDTH(5), .NUM_CH(3), .RR_MODE(ARB_RR)) dut_c (
        .clk(clk), .rst_n(rst_c), .in_data(data_c), .in_valid(valid_c), .in_ready(ready_c),
        .out_data(odata_c), .out_sel(sel_c), .out_valid(ovalid_c), .out_ready(oready_c)
    );

    logic [1:0] sweep_sel  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [4:0] sweep_data [6] = '{5'b10000, 5'b00010, 5'b00000, 5'b01101, 5'b10000, 5'b00010};
    logic [3:0] sweep_rdy  [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int which, input logic [3:0] valid, input logic ready);
        case (which)
            0: begin valid_a = valid;      oready_a = ready; end
            1: begin valid_b = valid;      oready_b = ready; end
            default: begin valid_c = valid[2:0]; oready_c = ready; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        data_a = {5'b01101, 5'b00000, 5'b00010, 5'b10000};
        data_b = data_a;
        data_c = {5'b00000, 5'b00010, 5'b10000};
        applyStimulus(0, 4'b1111, 1'b1);
        applyStimulus(1, 4'b0000, 1'b1);
        applyStimulus(2, 4'b0000, 1'b1);
        #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        #12;

        // Reset state with every channel requesting
        checkOutput("rst_out_valid", 32'(ovalid_a), 32'd0);
        checkOutput("rst_out_data",  32'(odata_a),  32'd0);
        checkOutput("rst_out_sel",   32'(sel_a),    32'd0);
        checkOutput("rst_in_ready",  32'(ready_a),  32'd0);

        @(negedge clk);
        rst_a = 1'b1;
        #1;
        checkOutput("first_grant_ch0", 32'(ready_a), 32'b0001);

        // Round-robin sweep, one beat per cycle
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput($sformatf("sweep%0d_sel", i),   32'(sel_a),    32'(sweep_sel[i]));
            checkOutput($sformatf("sweep%0d_data", i),  32'(odata_a),  32'(sweep_data[i]));
            checkOutput($sformatf("sweep%0d_valid", i), 32'(ovalid_a), 32'd1);
            checkOutput($sformatf("sweep%0d_ready", i), 32'(ready_a),  32'(sweep_rdy[i]));
        end

        // Backpressure after ch1 is accepted
        applyStimulus(0, 4'b1111, 1'b0);
        #1;
        checkOutput("stall_in_ready", 32'(ready_a), 32'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("stall%0d_sel", i),   32'(sel_a),    32'd1);
            checkOutput($sformatf("stall%0d_data", i),  32'(odata_a),  32'b00010);
            checkOutput($sformatf("stall%0d_valid", i), 32'(ovalid_a), 32'd1);
            checkOutput($sformatf("stall%0d_ready", i), 32'(ready_a),  32'b0000);
        end
        applyStimulus(0, 4'b1111, 1'b1);
        #1;
        checkOutput("unstall_ready_ch2", 32'(ready_a), 32'b0100);
        tick();
        checkOutput("unstall_sel",  32'(sel_a),   32'd2);
        checkOutput("unstall_data", 32'(odata_a), 32'b00000);

        // Sparse requests: walk ptr to 1, then only ch3 requests
        applyStimulus(0, 4'b0001, 1'b1);
        #1;
        checkOutput("wrap_ready_ch0", 32'(ready_a), 32'b0001);
        tick();
        checkOutput("wrap_sel", 32'(sel_a), 32'd0);
        applyStimulus(0, 4'b1000, 1'b1);
        #1;
        checkOutput("sparse_ready_ch3", 32'(ready_a), 32'b1000);
        tick();
        checkOutput("sparse_sel",  32'(sel_a),   32'd3);
        checkOutput("sparse_data", 32'(odata_a), 32'b01101);
        applyStimulus(0, 4'b0011, 1'b1);
        #1;
        checkOutput("ptr0_ready_ch0", 32'(ready_a), 32'b0001);
        tick();
        checkOutput("ptr0_sel",  32'(sel_a),   32'd0);
        checkOutput("ptr0_data", 32'(odata_a), 32'b10000);

        // Idle: beat drains, payload registers hold
        applyStimulus(0, 4'b0000, 1'b1);
        tick();
        checkOutput("idle_valid", 32'(ovalid_a), 32'd0);
        checkOutput("idle_sel",   32'(sel_a),    32'd0);
        checkOutput("idle_data",  32'(odata_a),  32'b10000);
        checkOutput("idle_ready", 32'(ready_a),  32'b0000);

        // Fixed priority
        @(negedge clk);
        rst_b = 1'b1;
        applyStimulus(1, 4'b1110, 1'b1);
        #1;
        checkOutput("fixed_ready_ch1", 32'(ready_b), 32'b0010);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("fixed%0d_sel", i),   32'(sel_b),   32'd1);
            checkOutput($sformatf("fixed%0d_data", i),  32'(odata_b), 32'b00010);
            checkOutput($sformatf("fixed%0d_ready", i), 32'(ready_b), 32'b0010);
        end
        applyStimulus(1, 4'b1000, 1'b1);
        #1;
        checkOutput("fixed_ready_ch3", 32'(ready_b), 32'b1000);
        tick();
        checkOutput("fixed_sel_ch3",  32'(sel_b),   32'd3);
        checkOutput("fixed_data_ch3", 32'(odata_b), 32'b01101);

        // Three channels: wrap skips index 3
        @(negedge clk);
        rst_c = 1'b1;
        applyStimulus(2, 4'b0111, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("odd%0d_sel", i),   32'(sel_c),    32'(i % 3));
            checkOutput($sformatf("odd%0d_valid", i), 32'(ovalid_c), 32'd1);
        end
        checkOutput("odd_data_ch0", 32'(odata_c), 32'b10000);

        // Asynchronous reset between clock edges
        #3;
        rst_c = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(ovalid_c), 32'd0);
        checkOutput("async_rst_sel",   32'(sel_c),    32'd0);
        checkOutput("async_rst_ready", 32'(ready_c),  32'd0);
        @(negedge clk);
        rst_c = 1'b1;
        #1;
        checkOutput("restart_ready_ch0", 32'(ready_c), 32'b001);
        tick();
        checkOutput("restart_sel",   32'(sel_c),    32'd0);
        checkOutput("restart_valid", 32'(ovalid_c), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
